// File: rtl/ui_arb_pkg.sv
// ui_arb_pkg: shared state encoding and grant constants for ui_stream_arbiter.
package ui_arb_pkg;
    localparam int REQ_N = 2;
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0 = 2'b01;
    localparam logic [1:0] GRANT_1 = 2'b10;
    // States double as the one-hot grant so grant_o is the state register itself
    typedef enum logic [1:0] {
        IDLE = GRANT_NONE,
        GNT0 = GRANT_0,
        GNT1 = GRANT_1
    } state_t;
endpackage

// File: rtl/ui_arb_watchdog.sv
// ui_arb_watchdog: counts stalled cycles inside a granted packet and pulses abort.
// Built only when UI_ARB_WATCHDOG_EN is defined.
module ui_arb_watchdog #(
    parameter int TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic valid,
    input  logic accept,
    output logic abort
);
    logic [15:0] cnt;

    // Fires on the TIMEOUT-th consecutive stalled cycle so the grant drops at the next edge
    assign abort = active && !valid && cnt == 16'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (!active || accept || abort) cnt <= '0;
        else if (!valid) cnt <= cnt + 16'd1;
    end
endmodule

// File: rtl/ui_stream_arbiter.sv
// ui_stream_arbiter: round-robin per-packet arbiter of two byte streams onto ui_in.
// Optional stall watchdog enabled by defining UI_ARB_WATCHDOG_EN.
module ui_stream_arbiter
    import ui_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [REQ_N-1:0]          req_valid_i,
    input  logic [REQ_N*DATA_W-1:0]   req_data_i,
    input  logic [REQ_N-1:0]          req_last_i,
    output logic [REQ_N-1:0]          req_ready_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      valid_o,
    output logic                      last_o,
    input  logic                      ready_i,
    output logic [REQ_N-1:0]          grant_o,
    output logic                      abort_o
);
    state_t state, state_nx;
    logic rr, cur, pick, accept, acc_last, abort;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("ui_stream_arbiter: TIMEOUT out of range");
    end

    assign cur = state == GNT1;
    assign grant_o = state;
    assign abort_o = abort;
    assign pick = &req_valid_i ? rr : req_valid_i[1];
    assign req_ready_o = state == IDLE ? 2'b00 : {cur, !cur} & {2{!valid_o || ready_i}};
    assign accept = |(req_ready_o & req_valid_i);
    assign acc_last = accept && req_last_i[cur];

    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = ena && |req_valid_i ? (pick ? GNT1 : GNT0) : IDLE;
        else if (acc_last || abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr <= 1'b0;
            data_o <= '0;
            valid_o <= 1'b0;
            last_o <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc_last || abort) rr <= !cur;
            if (accept) begin
                data_o <= cur ? req_data_i[2*DATA_W-1:DATA_W] : req_data_i[DATA_W-1:0];
                last_o <= req_last_i[cur];
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef UI_ARB_WATCHDOG_EN
    ui_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk(clk),
        .rst_n(rst_n),
        .active(state != IDLE),
        .valid(req_valid_i[cur]),
        .accept(accept),
        .abort(abort)
    );
`else
    assign abort = 1'b0;
`endif
endmodule
